// File: rtl/kbd_pkg.sv
// kbd_pkg: ASCII codes and line-buffer state type shared by the keyboard and console blocks
package kbd_pkg;
  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_BS       = 8'h08;
  localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
  localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;
  typedef enum logic {LB_S_EDIT, LB_S_DRAIN} lb_state_t;
  function automatic logic is_print(input logic [7:0] c);
    return c >= ASCII_PRINT_LO && c <= ASCII_PRINT_HI;
  endfunction
endpackage

// File: rtl/kbd_line_mem.sv
// kbd_line_mem: DEPTH x 8 line storage, one synchronous write port, one combinational read port
//   clk      clock
//   we_i     write enable; waddr_i/wdata_i write address/data
//   raddr_i  read address (driven from a register by the top)
//   rdata_o  byte at raddr_i
module kbd_line_mem #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/kbd_line_buf.sv
// kbd_line_buf: line editor with backspace, streams the finished line plus CR on valid/ready
//   clk, rst             clock, synchronous active-high reset
//   key_done, key_ascii  1-cycle key strobe and its ASCII byte
//   out_valid/out_data/out_last/out_ready  byte stream; out_last marks the trailing CR
//   line_len             chars currently stored
//   busy                 high while the line is being streamed
//   overflow, drop       1-cycle pulses: key lost to a full line / key lost while streaming
module kbd_line_buf
  import kbd_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_done,
  input  logic [7:0]  key_ascii,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic [AW:0] line_len,
  output logic        busy,
  output logic        overflow,
  output logic        drop
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);
  lb_state_t   state_q, state_d;
  logic [AW:0] len_q, len_d, rd_q, rd_d;
  logic        overflow_q, overflow_d, drop_q, drop_d;
  logic        draining, full, at_end, we, print;
  logic [7:0]  rd_byte;
  assign draining = state_q == LB_S_DRAIN;
  assign full     = len_q == FULL;
  assign at_end   = rd_q == len_q;
  assign print    = is_print(key_ascii);
  assign we       = !draining && key_done && print && !full;
  kbd_line_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (len_q[AW-1:0]),
    .wdata_i (key_ascii),
    .raddr_i (rd_q[AW-1:0]),
    .rdata_o (rd_byte)
  );
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rd_d       = rd_q;
    overflow_d = !draining && key_done && print && full;
    drop_d     = draining && key_done;
    if (we) len_d = len_q + ONE;
    else if (!draining && key_done && key_ascii == ASCII_BS && len_q != '0) len_d = len_q - ONE;
    else if (!draining && key_done && key_ascii == ASCII_CR) begin
      state_d = LB_S_DRAIN;
      rd_d    = '0;
    end
    if (draining && out_ready) begin
      state_d = at_end ? LB_S_EDIT : LB_S_DRAIN;
      len_d   = at_end ? '0 : len_q;
      rd_d    = at_end ? '0 : rd_q + ONE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LB_S_EDIT;
      len_q      <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rd_q       <= rd_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end
  // Output bytes come only from registered state, so they hold steady through a stall.
  assign out_valid = draining;
  assign out_last  = draining && at_end;
  assign out_data  = !draining ? 8'h00 : at_end ? ASCII_CR : rd_byte;
  assign busy      = draining;
  assign line_len  = len_q;
  assign overflow  = overflow_q;
  assign drop      = drop_q;
endmodule
